// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates fetch and mem-stage requests onto a byte-wide RAM port, serialising lane-masked words
module mem_arbiter_ctrl #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_done,
  output logic        stall_req,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  if (RAM_LAT != 1) begin : g_bad_lat
    $error("mem_arbiter_ctrl: RAM_LAT must be 1");
  end
  state_t      state, state_nx;
  logic        owner, we, pend, issue, done, grant;
  logic [29:0] base;
  logic [3:0]  rem, rem_nx, gsel;
  logic [1:0]  lane, pend_lane;
  logic [31:0] wdata, asm_w;
  logic        unused;
  assign unused = ^{if_addr_i[1:0], mem_addr_i[1:0]};
  always_comb begin
    lane      = rem[3] ? 2'd3 : rem[2] ? 2'd2 : rem[1] ? 2'd1 : 2'd0;
    rem_nx    = rem & ~(4'b0001 << lane);
    gsel      = mem_ce_i ? mem_sel_i : 4'b1111;
    grant     = mem_ce_i | if_req;
    issue     = state == ISSUE;
    done      = state == DONE;
    state_nx  = state == IDLE  ? (grant ? (gsel == 4'b0000 ? DONE : ISSUE) : IDLE)
              : state == ISSUE ? (rem_nx == 4'b0000 ? (we ? DONE : DRAIN) : ISSUE)
              : state == DRAIN ? DONE : IDLE;
    ram_addr_o = issue ? {base, ~lane} : 32'd0;
    ram_we_o   = issue & we;
    ram_dout_o = (issue & we) ? wdata[{lane, 3'b000} +: 8] : 8'd0;
    mem_done   = done & owner;
    if_done    = done & ~owner;
    mem_data_o = mem_done ? asm_w : 32'd0;
    if_data_o  = if_done ? asm_w : 32'd0;
    stall_req  = mem_ce_i & ~mem_done;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      we        <= 1'b0;
      base      <= '0;
      rem       <= '0;
      wdata     <= '0;
      asm_w     <= '0;
      pend      <= 1'b0;
      pend_lane <= '0;
    end else begin
      state     <= state_nx;
      pend      <= issue & ~we;
      pend_lane <= lane;
      if (pend) asm_w[{pend_lane, 3'b000} +: 8] <= ram_din_i;
      if (issue) rem <= rem_nx;
      if (state == IDLE && grant) begin
        owner <= mem_ce_i;
        we    <= mem_ce_i & mem_we_i;
        base  <= mem_ce_i ? mem_addr_i[31:2] : if_addr_i[31:2];
        rem   <= gsel;
        wdata <= mem_data_i;
        asm_w <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: directed self-checking bench with a 1-cycle-latency byte RAM model
module tb_mem_arbiter_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_done;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        mem_done;
  logic        stall_req;
  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = '0;
  logic [7:0]  ram [0:4095];
  int n = 0;
  int fails = 0;
  mem_arbiter_ctrl #(.RAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done(if_done),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_done(mem_done), .stall_req(stall_req),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o[11:0]] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o[11:0]];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
    ram[12'h200] <= 8'h01; ram[12'h201] <= 8'h02; ram[12'h202] <= 8'h03; ram[12'h203] <= 8'h04;
    ram[12'h300] <= 8'h5A; ram[12'h301] <= 8'h6B; ram[12'h302] <= 8'h7C; ram[12'h303] <= 8'h8D;
    ram[12'h400] <= 8'hAA; ram[12'h401] <= 8'hBB; ram[12'h402] <= 8'hCC; ram[12'h403] <= 8'hDD;
    tick; tick;
    chk("rst_we", ram_we_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b1;
    tick;
    mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'b1111; mem_addr_i = 32'h100;
    #1 chk("t1_stall_T", stall_req, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      mem_addr_i = 32'hFFF0;
      chk("t1_addr", ram_addr_o, 32'h100 + i);
      chk("t1_we", ram_we_o, 0);
      chk("t1_stall", stall_req, 1);
    end
    tick;
    chk("t1_drain_done", mem_done, 0);
    chk("t1_drain_addr", ram_addr_o, 0);
    tick;
    chk("t1_done", mem_done, 1);
    chk("t1_data", mem_data_o, 32'h11223344);
    chk("t1_stall_done", stall_req, 0);
    chk("t1_if_done", if_done, 0);
    mem_ce_i = 0;
    tick;
    chk("t1_idle_done", mem_done, 0);
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0010; mem_addr_i = 32'h202; mem_data_i = 32'hA5A5A5A5;
    tick;
    chk("t2_we", ram_we_o, 1);
    chk("t2_addr", ram_addr_o, 32'h202);
    chk("t2_dout", ram_dout_o, 8'hA5);
    tick;
    chk("t2_done", mem_done, 1);
    chk("t2_we_off", ram_we_o, 0);
    mem_ce_i = 0;
    tick;
    chk("t2_ram200", ram[12'h200], 8'h01);
    chk("t2_ram201", ram[12'h201], 8'h02);
    chk("t2_ram202", ram[12'h202], 8'hA5);
    chk("t2_ram203", ram[12'h203], 8'h04);
    mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'b1100; mem_addr_i = 32'h300;
    if_req = 1; if_addr_i = 32'h101;
    tick;
    chk("t3_addr0", ram_addr_o, 32'h300);
    tick;
    chk("t3_addr1", ram_addr_o, 32'h301);
    tick;
    chk("t3_drain_if", if_done, 0);
    tick;
    chk("t3_mem_done", mem_done, 1);
    chk("t3_mem_data", mem_data_o, 32'h5A6B0000);
    chk("t3_if_done_n", if_done, 0);
    mem_ce_i = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t3_wait_if", if_done, 0);
      chk("t3_wait_mem", mem_done, 0);
      if (i >= 1 && i <= 4) chk("t3_faddr", ram_addr_o, 32'h100 + i - 1);
    end
    tick;
    chk("t3_if_done", if_done, 1);
    chk("t3_if_data", if_data_o, 32'h11223344);
    chk("t3_mem_quiet", mem_done, 0);
    if_req = 0;
    tick;
    mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'b1010; mem_addr_i = 32'h400;
    tick;
    chk("t4_addr0", ram_addr_o, 32'h400);
    tick;
    chk("t4_addr1", ram_addr_o, 32'h402);
    tick;
    chk("t4_drain", mem_done, 0);
    tick;
    chk("t4_done", mem_done, 1);
    chk("t4_data", mem_data_o, 32'hAA00CC00);
    mem_ce_i = 0;
    tick;
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b1111; mem_addr_i = 32'h500; mem_data_i = 32'h12345678;
    tick;
    chk("t5_w0", ram_addr_o, 32'h500);
    tick;
    chk("t5_w1", ram_addr_o, 32'h501);
    chk("t5_d1", ram_dout_o, 8'h34);
    rst = 0;
    tick;
    mem_ce_i = 0;
    chk("t5_we", ram_we_o, 0);
    chk("t5_addr", ram_addr_o, 0);
    chk("t5_dout", ram_dout_o, 0);
    chk("t5_mem_done", mem_done, 0);
    chk("t5_if_done", if_done, 0);
    chk("t5_mem_data", mem_data_o, 0);
    chk("t5_if_data", if_data_o, 0);
    rst = 1;
    tick;
    chk("t5_no_done", mem_done, 0);
    chk("t5_ram500", ram[12'h500], 8'h12);
    chk("t5_ram501", ram[12'h501], 8'h34);
    chk("t5_ram502", ram[12'h502], 8'h00);
    chk("t5_ram503", ram[12'h503], 8'h00);
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0000; mem_addr_i = 32'h600; mem_data_i = 32'hFFFFFFFF;
    #1 chk("t6_we_T", ram_we_o, 0);
    tick;
    chk("t6_done", mem_done, 1);
    chk("t6_we", ram_we_o, 0);
    chk("t6_data", mem_data_o, 0);
    chk("t6_stall", stall_req, 0);
    mem_ce_i = 0;
    tick;
    chk("t6_idle", mem_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
